// File: rtl/dcache_sram_arbiter_if.sv
// Requester-side bus of the dcache SRAM arbiter: per-port request/write/address/data in,
// one-hot grant, per-port read-valid and the shared read data out.
interface dcache_sram_arbiter_if #(
  parameter int unsigned NR_PORTS   = 5,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned DATA_WIDTH = 128
);
  // Handshake: a port raises req_i with we_i/addr_i/wdata_i stable and holds them until it sees
  // gnt_o for itself in the same cycle (transfer happens on that clock edge); a granted read
  // returns rdata_o qualified by rvalid_o exactly one cycle later; writes return nothing.
  logic [NR_PORTS-1:0]                          req_i;
  logic [NR_PORTS-1:0]                          we_i;
  logic [NR_PORTS-1:0][$clog2(NUM_WORDS)-1:0]   addr_i;
  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]          wdata_i;
  logic [NR_PORTS-1:0]                          gnt_o;
  logic [NR_PORTS-1:0]                          rvalid_o;
  logic [DATA_WIDTH-1:0]                        rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/dcache_sram_arbiter.sv
// Single-port data-array arbiter: zeroes every row after reset or on init_ni, then grants the
// SRAM to the miss handler (port 0, starvation-bounded) or round-robin among cache controllers.
module dcache_sram_arbiter #(
  parameter int unsigned NR_PORTS     = 5,
  parameter int unsigned NUM_WORDS    = 256,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          init_ni,
  dcache_sram_arbiter_if.slave          bus,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [$clog2(NUM_WORDS)-1:0]  sram_addr_o,
  output logic [DATA_WIDTH-1:0]         sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]         sram_rdata_i,
  output logic                          init_done_o,
  output logic                          dbg_state_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {
    SWEEP = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [AW-1:0]       r_sweep_cnt, w_sweep_cnt_nxt;
  logic [PW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [SW-1:0]       r_starve_cnt, w_starve_cnt_nxt;
  logic [NR_PORTS-1:0] r_rvalid;
  logic [NR_PORTS-1:0] w_gnt;
  logic [PW-1:0]       w_gnt_idx;
  logic                w_others_req;
  logic                w_rr_found;
  logic [PW-1:0]       w_rr_idx;

  // Round-robin search over ports 1..NR_PORTS-1 starting at the pointer; port 0 never competes here.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] cand;
    idx          = 0;
    cand         = '0;
    w_others_req = 1'b0;
    w_rr_found   = 1'b0;
    w_rr_idx     = r_rr_ptr;
    for (int unsigned p = 1; p < NR_PORTS; p++) begin
      if (bus.req_i[p]) w_others_req = 1'b1;
    end
    for (int unsigned k = 0; k < NR_PORTS - 1; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NR_PORTS) idx = idx - (NR_PORTS - 1);
      cand = idx[PW-1:0];
      if (!w_rr_found && bus.req_i[cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = cand;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sweep_cnt_nxt  = r_sweep_cnt;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_starve_cnt_nxt = r_starve_cnt;
    w_gnt            = '0;
    w_gnt_idx        = '0;
    sram_req_o       = 1'b0;
    sram_we_o        = 1'b0;
    sram_addr_o      = '0;
    sram_wdata_o     = '0;
    init_done_o      = 1'b0;
    case (r_state)
      SWEEP: begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = r_sweep_cnt;
        if (!init_ni) begin
          w_sweep_cnt_nxt = '0;
        end else begin
          w_sweep_cnt_nxt = r_sweep_cnt + 1'b1;
          if (r_sweep_cnt == AW'(NUM_WORDS - 1)) w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        init_done_o = 1'b1;
        // Port 0 loses its priority only while someone else is actually waiting.
        if (bus.req_i[0] && ((32'(r_starve_cnt) < STARVE_LIMIT) || !w_others_req)) begin
          w_gnt[0]  = 1'b1;
          w_gnt_idx = '0;
        end else if (w_rr_found) begin
          w_gnt[w_rr_idx] = 1'b1;
          w_gnt_idx       = w_rr_idx;
          w_rr_ptr_nxt    = (32'(w_rr_idx) == NR_PORTS - 1) ? PW'(1) : w_rr_idx + 1'b1;
        end
        if (w_gnt[0] && w_others_req) begin
          if (32'(r_starve_cnt) < STARVE_LIMIT) w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end else begin
          w_starve_cnt_nxt = '0;
        end
        sram_req_o = |w_gnt;
        if (|w_gnt) begin
          sram_we_o    = bus.we_i[w_gnt_idx];
          sram_addr_o  = bus.addr_i[w_gnt_idx];
          sram_wdata_o = bus.wdata_i[w_gnt_idx];
        end
        if (!init_ni) begin
          w_state_nxt     = SWEEP;
          w_sweep_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = SWEEP;
        w_sweep_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= SWEEP;
      r_sweep_cnt  <= '0;
      r_rr_ptr     <= PW'(1);
      r_starve_cnt <= '0;
      r_rvalid     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sweep_cnt  <= w_sweep_cnt_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_rvalid     <= w_gnt & ~bus.we_i;
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = sram_rdata_i;
  assign dbg_state_o  = r_state;

endmodule
